vga_timing_gen: RTL and testbench

Parametrised VGA/DVI raster timing generator. Replaces the fixed 640x480 sync generator used by the pong/video demos.
- Porches, sync widths and sync polarities are set by parameters.
- Adds a pixel clock-enable, so one fast system clock can drive slower pixel rates.
- Provides registered hsync, vsync, de, x/y coordinates and line/frame strobes for downstream pixel pipelines.

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_axis_cnt.sv | 64 ++++++
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA/DVI raster timing generator.
//
// Contents:
//   - Timing sets for 640x480@60 (VGA640_*) and 800x600@60 (SVGA800_*).
//   - vga_clog2(): the number of bits needed to count 0..value-1. It sets the
//     default X_W/Y_W widths and checks user-supplied widths.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam bit VGA640_V_POL    = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_H_POL    = 1'b1;
  localparam bit SVGA800_V_POL    = 1'b1;

  // Bits needed to represent value-1, with a minimum of one bit.
  // Example: 800 -> 10, 525 -> 10, 8 -> 3.
  function automatic int vga_clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One axis (horizontal or vertical) of the raster: a wrapping position
// counter plus a combinational decode of where that position lies.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset, clears the count to 0
//   inc_i     advance the count by one on this clock
//   wrap_i    together with inc_i, load 0 instead of count+1
//   count_o   current position, 0..TOTAL-1
//   active_o  count < ACTIVE
//   sync_o    count is inside the sync window [ACTIVE+FP, ACTIVE+FP+SYNC)
//   last_o    count == TOTAL-1
module vga_axis_cnt #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         wrap_i,
  output logic [W-1:0] count_o,
  output logic         active_o,
  output logic         sync_o,
  output logic         last_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Boundaries as W-bit constants so every compare is width-matched.
  // SYNC_END is at most TOTAL-1 because BP >= 1, so it always fits in W bits.
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next position. The owner decides when to wrap, so the horizontal axis
  // can wrap on its own last flag and the vertical axis on its own.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = wrap_i ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign active_o = (count_q < ACT_END);
  assign sync_o   = (count_q >= SYNC_START) && (count_q < SYNC_END);
  assign last_o   = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with a pixel clock-enable.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pix_en       pixel clock-enable; the raster moves one pixel per enabled clk
//   hsync        horizontal sync, active level H_POL
//   vsync        vertical sync, active level V_POL (held for whole lines)
//   de           display enable, high inside the visible area
//   x, y         position of the pixel the other outputs describe
//   line_start   one-clk strobe when the pixel at h=0 is output
//   frame_start  one-clk strobe when the pixel at (0,0) is output
//   vblank       high while y >= V_ACTIVE
//
// Each enabled clock registers the decode of the counter position from
// before the increment. All outputs therefore describe the same pixel,
// one clock behind the counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = VGA640_H_POL,
  parameter bit V_POL    = VGA640_V_POL,
  parameter int X_W      = vga_clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int Y_W      = vga_clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start,
  output logic           vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject parameter sets that cannot describe a raster
  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0) begin : g_bad_h
    $error("vga_timing_gen: every horizontal timing parameter must be > 0");
  end
  if (V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_v
    $error("vga_timing_gen: every vertical timing parameter must be > 0");
  end
  if (X_W < vga_clog2(H_TOTAL)) begin : g_bad_xw
    $error("vga_timing_gen: X_W too small to hold H_TOTAL-1");
  end
  if (Y_W < vga_clog2(V_TOTAL)) begin : g_bad_yw
    $error("vga_timing_gen: Y_W too small to hold V_TOTAL-1");
  end

  logic [X_W-1:0] h_cnt;
  logic           h_active;
  logic           h_sync;
  logic           h_last;
  logic [Y_W-1:0] v_cnt;
  logic           v_active;
  logic           v_sync;
  logic           v_last;
  logic           v_inc;

  // The vertical axis advances only on the enabled clock that wraps the line
  assign v_inc = pix_en & h_last;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (X_W)
  ) u_h_cnt (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .inc_i    (pix_en),
    .wrap_i   (h_last),
    .count_o  (h_cnt),
    .active_o (h_active),
    .sync_o   (h_sync),
    .last_o   (h_last)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (Y_W)
  ) u_v_cnt (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .inc_i    (v_inc),
    .wrap_i   (v_last),
    .count_o  (v_cnt),
    .active_o (v_active),
    .sync_o   (v_sync),
    .last_o   (v_last)
  );

  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic           vblank_q, vblank_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           h_first;
  logic           v_first;

  assign h_first = (h_cnt == '0);
  assign v_first = (v_cnt == '0);

  // Level outputs hold while pix_en is low. The strobes default to 0, so
  // they drop on the clock after they are set, even when pix_en is low.
  // This keeps each strobe exactly one system clock wide.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    vblank_d      = vblank_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      x_d           = h_cnt;
      y_d           = v_cnt;
      de_d          = h_active & v_active;
      hsync_d       = h_sync ? H_POL : ~H_POL;
      vsync_d       = v_sync ? V_POL : ~V_POL;
      vblank_d      = ~v_active;
      line_start_d  = h_first;
      frame_start_d = h_first & v_first;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      vblank_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      vblank_q      <= vblank_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign vblank      = vblank_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. It drives three instances:
//   dut_a  tiny raster H 4/1/2/1, V 3/1/1/1, active-low syncs
//   dut_b  same raster with active-high syncs (shares pix_en with dut_a)
//   dut_c  default 640x480 timing with pix_en tied high
module tb_vga_timing_gen;

  localparam int HA = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic       pix_en_c = 1'b1;

  logic       a_hs, a_vs, a_de, a_ls, a_fs, a_vb;
  logic [2:0] a_x, a_y;
  logic       b_hs, b_vs, b_de, b_ls, b_fs, b_vb;
  logic [2:0] b_x, b_y;
  logic       c_hs, c_vs, c_de, c_ls, c_fs, c_vb;
  logic [9:0] c_x, c_y;

  int checks = 0;
  int errors = 0;

  // Reference model of dut_a: raster position plus the expected outputs
  int mh, mv;
  int e_x, e_y;
  bit e_de, e_hs, e_vs, e_vb, e_ls, e_fs;

  typedef struct {
    bit en;
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
    bit vb;
    bit ls;
    bit fs;
  } vec_t;

  vec_t vecs[13];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs), .vblank(a_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs), .vblank(b_vb)
  );

  vga_timing_gen dut_c (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en_c),
    .hsync(c_hs), .vsync(c_vs), .de(c_de), .x(c_x), .y(c_y),
    .line_start(c_ls), .frame_start(c_fs), .vblank(c_vb)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mh = 0; mv = 0;
    e_x = 0; e_y = 0;
    e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0;
    e_ls = 1'b0; e_fs = 1'b0;
  endtask

  // Predict the outputs after one clock with the given enable, then advance
  task automatic modelStep(input bit en);
    if (en) begin
      e_x  = mh;
      e_y  = mv;
      e_de = (mh < HA) && (mv < VA);
      e_hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
      e_vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
      e_vb = (mv >= VA);
      e_ls = (mh == 0);
      e_fs = (mh == 0) && (mv == 0);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end else begin
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
  endtask

  // Compare dut_a with the model; dut_b must match except for inverted syncs
  task automatic checkAll(input string tag);
    checkOutput({tag, ".x"}, int'(a_x), e_x);
    checkOutput({tag, ".y"}, int'(a_y), e_y);
    checkOutput({tag, ".de"}, int'(a_de), int'(e_de));
    checkOutput({tag, ".hsync"}, int'(a_hs), int'(e_hs));
    checkOutput({tag, ".vsync"}, int'(a_vs), int'(e_vs));
    checkOutput({tag, ".vblank"}, int'(a_vb), int'(e_vb));
    checkOutput({tag, ".line_start"}, int'(a_ls), int'(e_ls));
    checkOutput({tag, ".frame_start"}, int'(a_fs), int'(e_fs));
    checkOutput({tag, ".b_hsync"}, int'(b_hs), int'(!e_hs));
    checkOutput({tag, ".b_vsync"}, int'(b_vs), int'(!e_vs));
    checkOutput({tag, ".b_x"}, int'(b_x), e_x);
    checkOutput({tag, ".b_de"}, int'(b_de), int'(e_de));
    checkOutput({tag, ".b_frame_start"}, int'(b_fs), int'(e_fs));
  endtask

  // One clock with the given enable; sample 1 ns after the rising edge
  task automatic applyStimulus(input bit en);
    @(negedge clk);
    pix_en = en;
    @(posedge clk);
    #1;
    modelStep(en);
  endtask

  // Hold reset for two clocks and release it on a falling edge with pix_en low
  task automatic doReset();
    pix_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Main sequence: vector table, full frames, gated enable, mid-frame reset,
  // then line measurements on the default 640x480 instance
  initial begin
    int fs_cnt, ls_cnt, vs_low, vb_high, en_cnt, period;
    int n, hs_low, de_cnt;
    bit seen;

    // Hand-computed first cycles: en, x, y, de, hs, vs, vb, ls, fs
    vecs[0]  = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 6, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 7, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 7, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 7, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    pix_en = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    checkAll("reset");
    checkOutput("reset.c_hsync", int'(c_hs), 1);
    checkOutput("reset.c_x", int'(c_x), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      pix_en = vecs[i].en;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d.x", i), int'(a_x), vecs[i].x);
      checkOutput($sformatf("vec%0d.y", i), int'(a_y), vecs[i].y);
      checkOutput($sformatf("vec%0d.de", i), int'(a_de), int'(vecs[i].de));
      checkOutput($sformatf("vec%0d.hsync", i), int'(a_hs), int'(vecs[i].hs));
      checkOutput($sformatf("vec%0d.vsync", i), int'(a_vs), int'(vecs[i].vs));
      checkOutput($sformatf("vec%0d.vblank", i), int'(a_vb), int'(vecs[i].vb));
      checkOutput($sformatf("vec%0d.line_start", i), int'(a_ls), int'(vecs[i].ls));
      checkOutput($sformatf("vec%0d.frame_start", i), int'(a_fs), int'(vecs[i].fs));
      checkOutput($sformatf("vec%0d.b_hsync", i), int'(b_hs), int'(!vecs[i].hs));
      checkOutput($sformatf("vec%0d.b_vsync", i), int'(b_vs), int'(!vecs[i].vs));
      checkOutput($sformatf("vec%0d.b_y", i), int'(b_y), vecs[i].y);
    end

    $display("[TB] free-running frame");
    doReset();
    fs_cnt = 0; ls_cnt = 0; vs_low = 0; vb_high = 0;
    for (int i = 0; i < HT * VT; i++) begin
      applyStimulus(1'b1);
      checkAll("run");
      if (a_fs) fs_cnt++;
      if (a_ls) ls_cnt++;
      if (!a_vs) vs_low++;
      if (a_vb) vb_high++;
    end
    checkOutput("run.frame_starts", fs_cnt, 1);
    checkOutput("run.line_starts", ls_cnt, VT);
    checkOutput("run.vsync_low_clks", vs_low, HT);
    checkOutput("run.vblank_clks", vb_high, HT * (VT - VA));
    applyStimulus(1'b1);
    checkAll("run.wrap");
    checkOutput("run.second_frame_start", int'(a_fs), 1);

    $display("[TB] gated pix_en 1,0,0,1");
    doReset();
    fs_cnt = 0; ls_cnt = 0; en_cnt = 0;
    for (int k = 0; k < 4 * HT * VT / 2; k++) begin
      applyStimulus((k % 4 == 0) || (k % 4 == 3));
      checkAll("gate");
      if (a_fs) fs_cnt++;
      if (a_ls) ls_cnt++;
      if ((k % 4 == 0) || (k % 4 == 3)) en_cnt++;
    end
    checkOutput("gate.enabled_clks", en_cnt, HT * VT);
    checkOutput("gate.frame_start_clks", fs_cnt, 1);
    checkOutput("gate.line_start_clks", ls_cnt, VT);
    period = 0;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      applyStimulus((k % 4 == 0) || (k % 4 == 3));
      checkAll("gate.next");
      if ((k % 4 == 0) || (k % 4 == 3)) period++;
      if (a_fs) seen = 1'b1;
    end
    checkOutput("gate.next_frame_seen", int'(seen), 1);
    checkOutput("gate.frame_period", en_cnt + period - 1, HT * VT);

    $display("[TB] reset at (6,2)");
    doReset();
    for (int i = 0; i < 2 * HT + 7; i++) begin
      applyStimulus(1'b1);
      checkAll("pre_rst");
    end
    checkOutput("pre_rst.x", int'(a_x), 6);
    checkOutput("pre_rst.y", int'(a_y), 2);
    #2;
    rst_n  = 1'b0;
    pix_en = 1'b0;
    #1;
    modelReset();
    checkAll("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1);
    checkAll("post_rst");
    checkOutput("post_rst.frame_start", int'(a_fs), 1);

    $display("[TB] default 640x480 line");
    doReset();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (c_ls) seen = 1'b1;
    end
    checkOutput("c.first_line_start", int'(seen), 1);
    checkOutput("c.first_x", int'(c_x), 0);
    checkOutput("c.first_y", int'(c_y), 0);
    checkOutput("c.first_frame_start", int'(c_fs), 1);
    checkOutput("c.first_de", int'(c_de), 1);
    n = 0; hs_low = 0; de_cnt = 0;
    do begin
      if (!c_hs) hs_low++;
      if (c_de) de_cnt++;
      n++;
      @(posedge clk);
      #1;
    end while (!c_ls && n < 2000);
    checkOutput("c.line_period", n, 800);
    checkOutput("c.hsync_width", hs_low, 96);
    checkOutput("c.de_per_line", de_cnt, 640);
    checkOutput("c.second_line_y", int'(c_y), 1);
    checkOutput("c.vsync_idle", int'(c_vs), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
